pr_timer_bridge: RTL and testbench

//  Device-side responder for the CPU processor bus (PrAddr/PrWD/PrWE/PrBE/PrRD, HWInt).

---
 rtl/pr_timer_pkg.sv | 47 ++++
 rtl/pr_timer.sv | 123 ++++++++++++
 rtl/pr_timer_bridge.sv | 63 ++++++
 tb/tb_pr_timer_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_timer_pkg.sv
// Shared definitions for the processor-bus timer bridge: timer FSM states,
// register offsets within a timer window, CTRL bit positions, mode codes and
// the byte-lane merge helper used when PR_BYTE_LANE_EN is defined.
package pr_timer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CTRL_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tmr_state_e;

  // Word offsets (PrAddr[3:2]) inside a timer window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;

  // Mode 1 reloads automatically; every other code behaves as one-shot
  localparam logic [1:0] MODE_AUTO = 2'd1;

  // Merge a write into an existing word; be==0 means full word
  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_v,
                                                 input logic [DATA_W-1:0] new_v,
                                                 input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_v;
    if (be == 4'b0000) begin
      r = new_v;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pr_timer.sv
// One countdown timer: CTRL/PRESET/COUNT registers, IDLE/LOAD/CNT/INT FSM
// and the interrupt flag.
// Ports: clk, reset (sync, active-low), we (decoded write for this window),
//        offset (word select), wdata, be (byte enables), rdata (combinational
//        read of the selected register), irq (flag masked by CTRL.IM).
// Build option: PR_BYTE_LANE_EN enables byte-lane writes to CTRL/PRESET.
module pr_timer
  import pr_timer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  tmr_state_e        state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              flag_q, flag_d;

  logic              wr_ctrl, wr_preset, en, mode_auto;
  logic [CTRL_W-1:0] ctrl_wr;
  logic [DATA_W-1:0] preset_wr;

  assign wr_ctrl   = we && (offset == OFF_CTRL);
  assign wr_preset = we && (offset == OFF_PRESET);
  assign en        = ctrl_q[CTRL_EN];
  assign mode_auto = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

  // Value a bus write would leave in each writable register
`ifdef PR_BYTE_LANE_EN
  assign ctrl_wr   = CTRL_W'(be_merge({28'd0, ctrl_q}, wdata, be));
  assign preset_wr = be_merge(preset_q, wdata, be);
`else
  logic unused_be;
  assign unused_be = ^be;
  assign ctrl_wr   = wdata[CTRL_W-1:0];
  assign preset_wr = wdata;
`endif

  // Next state: FSM step from current registers, then bus writes override
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = '0;
          state_d = ST_INT;
          flag_d  = 1'b1;
        end
      end
      ST_INT: begin
        if (mode_auto) begin
          state_d = ST_LOAD;
          flag_d  = 1'b0;
        end else begin
          ctrl_d[CTRL_EN] = 1'b0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A CTRL write acknowledges the flag, except one that raises IM: unmasking
    // must expose a pending interrupt rather than silently drop it.
    if (wr_ctrl) begin
      ctrl_d = ctrl_wr;
      if (!(ctrl_wr[CTRL_IM] && !ctrl_q[CTRL_IM])) flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = preset_wr;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Combinational read of the selected register
  always_comb begin
    case (offset)
      OFF_CTRL:   rdata = {28'd0, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      default:    rdata = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[CTRL_IM];

endmodule

// File: rtl/pr_timer_bridge.sv
// Processor-bus responder: decodes two timer windows, steers writes, muxes
// combinational read data and assembles HWInt.
// Ports: clk, reset (sync, active-low), PrAddr/PrWD/PrWE/PrBE (CPU bus),
//        ext_int (external interrupt levels), PrRD (read data, combinational
//        from PrAddr), HWInt ([2]=timer0, [3]=timer1, upper bits=ext_int).
// Build option: PR_BYTE_LANE_EN enables byte-lane writes to CTRL/PRESET.
module pr_timer_bridge
  import pr_timer_pkg::*;
#(
  parameter logic [31:0] BASE0     = 32'h0000_7f00,
  parameter logic [31:0] BASE1     = 32'h0000_7f10,
  parameter int unsigned EXT_INT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      PrAddr,
  input  logic [DATA_W-1:0]      PrWD,
  input  logic                   PrWE,
  input  logic [BE_W-1:0]        PrBE,
  input  logic [EXT_INT_W-1:0]   ext_int,
  output logic [DATA_W-1:0]      PrRD,
  output logic [EXT_INT_W+3:2]   HWInt
);

  logic              hit0, hit1, irq0, irq1;
  logic [DATA_W-1:0] rd0, rd1;

  // Each window spans CTRL, PRESET, COUNT (12 bytes)
  assign hit0 = (PrAddr >= BASE0) && (PrAddr <= BASE0 + 32'd11);
  assign hit1 = (PrAddr >= BASE1) && (PrAddr <= BASE1 + 32'd11);

  pr_timer u_timer0 (
    .clk    (clk),
    .reset  (reset),
    .we     (PrWE && hit0),
    .offset (PrAddr[3:2]),
    .wdata  (PrWD),
    .be     (PrBE),
    .rdata  (rd0),
    .irq    (irq0)
  );

  pr_timer u_timer1 (
    .clk    (clk),
    .reset  (reset),
    .we     (PrWE && hit1),
    .offset (PrAddr[3:2]),
    .wdata  (PrWD),
    .be     (PrBE),
    .rdata  (rd1),
    .irq    (irq1)
  );

  // Unmapped addresses read as zero
  always_comb begin
    if (hit0)      PrRD = rd0;
    else if (hit1) PrRD = rd1;
    else           PrRD = '0;
  end

  assign HWInt = {ext_int, irq1, irq0};

endmodule

// File: tb/tb_pr_timer_bridge.sv
module tb_pr_timer_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PrAddr, PrWD, PrRD;
  logic        PrWE;
  logic [3:0]  PrBE, ext_int;
  logic [7:2]  HWInt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pr_timer_bridge dut (
    .clk     (clk),
    .reset   (reset),
    .PrAddr  (PrAddr),
    .PrWD    (PrWD),
    .PrWE    (PrWE),
    .PrBE    (PrBE),
    .ext_int (ext_int),
    .PrRD    (PrRD),
    .HWInt   (HWInt)
  );

  // Reference model: register contents plus the documented timer phase
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_CNT  = 2;
  localparam int P_INT  = 3;

  logic [3:0]  m_ctrl   [2];
  logic [31:0] m_preset [2];
  logic [31:0] m_count  [2];
  bit          m_flag   [2];
  int          m_phase  [2];

  logic [3:0]  o_ctrl, n_ctrl, be_eff;
  logic [31:0] o_preset, o_count;
  int          o_phase;
  bit          wr_c, wr_p;

  function automatic int win(input logic [31:0] a);
    if (a >= 32'h7f00 && a <= 32'h7f0b) return 1;
    if (a >= 32'h7f10 && a <= 32'h7f1b) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = n;
    if (be != 4'b0000) begin
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    int w;
    w = win(a);
    if (w == 0) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, m_ctrl[w-1]};
      2'd1:    return m_preset[w-1];
      2'd2:    return m_count[w-1];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [7:2] model_hw();
    return {ext_int, m_flag[1] & m_ctrl[1][3], m_flag[0] & m_ctrl[0][3]};
  endfunction

  // Advance the model by one clock using the inputs about to be sampled
  task automatic model_advance();
`ifdef PR_BYTE_LANE_EN
    be_eff = PrBE;
`else
    be_eff = 4'b0000;
`endif
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_ctrl[i] = 4'd0; m_preset[i] = 32'd0; m_count[i] = 32'd0;
        m_flag[i] = 1'b0; m_phase[i] = P_IDLE;
      end else begin
        o_ctrl = m_ctrl[i]; o_preset = m_preset[i]; o_count = m_count[i]; o_phase = m_phase[i];
        wr_c = PrWE && (win(PrAddr) == i + 1) && (PrAddr[3:2] == 2'd0);
        wr_p = PrWE && (win(PrAddr) == i + 1) && (PrAddr[3:2] == 2'd1);
        case (o_phase)
          P_IDLE: if (o_ctrl[0]) m_phase[i] = P_LOAD;
          P_LOAD: begin m_count[i] = o_preset; m_phase[i] = P_CNT; end
          P_CNT: begin
            if (!o_ctrl[0]) m_phase[i] = P_IDLE;
            else if (o_count > 1) m_count[i] = o_count - 1;
            else begin m_count[i] = 32'd0; m_phase[i] = P_INT; m_flag[i] = 1'b1; end
          end
          default: begin
            if (o_ctrl[2:1] == 2'd1) begin m_phase[i] = P_LOAD; m_flag[i] = 1'b0; end
            else begin m_ctrl[i][0] = 1'b0; m_phase[i] = P_IDLE; end
          end
        endcase
        if (wr_c) begin
          n_ctrl = 4'(lane_merge({28'd0, o_ctrl}, PrWD, be_eff));
          if (!(n_ctrl[3] && !o_ctrl[3])) m_flag[i] = 1'b0;
          m_ctrl[i] = n_ctrl;
        end
        if (wr_p) begin
          m_preset[i] = lane_merge(o_preset, PrWD, be_eff);
          m_flag[i]   = 1'b0;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One clock: model step, edge, then compare outputs on the falling edge
  task automatic step();
    model_advance();
    @(posedge clk);
    @(negedge clk);
    chk("prrd_vs_model", PrRD, model_rd(PrAddr));
    chk("hwint_vs_model", {26'd0, HWInt}, {26'd0, model_hw()});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    PrAddr = a; PrWD = d; PrWE = 1'b1;
    step();
    PrWE = 1'b0;
  endtask

  task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
    PrAddr = a;
    #1;
    chk(nm, PrRD, exp);
  endtask

  bit          pulses [16];
  bit          seen;

  initial begin
    reset = 1'b0; PrAddr = 32'd0; PrWD = 32'd0; PrWE = 1'b0; PrBE = 4'd0; ext_int = 4'd0;
    run(2);
    reset = 1'b1;
    peek("reset_ctrl0", 32'h7f00, 32'd0);
    peek("reset_count1", 32'h7f18, 32'd0);
    chk("reset_hwint", {26'd0, HWInt}, 32'd0);

    // One-shot, PRESET=5
    bus_wr(32'h7f04, 32'd5);
    bus_wr(32'h7f00, 32'h9);
    PrAddr = 32'h7f08;
    step();
    chk("t1_load_count", PrRD, 32'd0);
    step();
    chk("t1_count5", PrRD, 32'd5);
    for (int v = 4; v >= 1; v--) begin
      step();
      chk("t1_countdown", PrRD, 32'(v));
    end
    step();
    chk("t1_count0", PrRD, 32'd0);
    chk("t1_irq_set", {31'd0, HWInt[2]}, 32'd1);
    run(3);
    chk("t1_irq_held", {31'd0, HWInt[2]}, 32'd1);
    peek("t1_ctrl_en_cleared", 32'h7f00, 32'h8);
    bus_wr(32'h7f00, 32'd0);
    chk("t1_irq_cleared", {31'd0, HWInt[2]}, 32'd0);

    // Auto-reload, PRESET=3: pulses every 5 edges
    bus_wr(32'h7f04, 32'd3);
    bus_wr(32'h7f00, 32'hB);
    PrAddr = 32'h7f08;
    for (int k = 1; k <= 15; k++) begin
      step();
      pulses[k] = HWInt[2];
    end
    for (int k = 1; k <= 15; k++) chk("t2_pulse", {31'd0, pulses[k]}, {31'd0, (k % 5) == 0});
    bus_wr(32'h7f00, 32'd0);
    run(4);

    // Disable mid-count freezes COUNT
    bus_wr(32'h7f04, 32'd6);
    bus_wr(32'h7f00, 32'h9);
    PrAddr = 32'h7f08;
    run(4);
    chk("t3_count4", PrRD, 32'd4);
    bus_wr(32'h7f00, 32'd0);
    PrAddr = 32'h7f08;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | HWInt[2];
    end
    chk("t3_count_held", PrRD, 32'd3);
    chk("t3_no_irq", {31'd0, seen}, 32'd0);

    // Masked interrupt, then unmask
    bus_wr(32'h7f04, 32'd2);
    bus_wr(32'h7f00, 32'h1);
    PrAddr = 32'h7f08;
    run(8);
    chk("t4_count0", PrRD, 32'd0);
    chk("t4_masked", {31'd0, HWInt[2]}, 32'd0);
    peek("t4_ctrl", 32'h7f00, 32'd0);
    bus_wr(32'h7f00, 32'h8);
    chk("t4_unmasked", {31'd0, HWInt[2]}, 32'd1);
    bus_wr(32'h7f00, 32'd0);
    chk("t4_ack", {31'd0, HWInt[2]}, 32'd0);

    // Decode, read-only COUNT, unmapped address, ext_int passthrough
    bus_wr(32'h7f14, 32'd7);
    peek("t5_preset1", 32'h7f14, 32'd7);
    peek("t5_preset0_kept", 32'h7f04, 32'd2);
    peek("t5_unmapped", 32'h7f20, 32'd0);
    bus_wr(32'h7f08, 32'h55);
    peek("t5_count_ro", 32'h7f08, 32'd0);
    bus_wr(32'h7f20, 32'h1234);
    ext_int = 4'b1010;
    #1;
    chk("t5_ext_int", {28'd0, HWInt[7:4]}, 32'hA);
    bus_wr(32'h7f10, 32'h9);
    PrAddr = 32'h7f18;
    run(10);
    chk("t5_timer1_irq", {31'd0, HWInt[3]}, 32'd1);
    peek("t5_ctrl1", 32'h7f10, 32'h8);

    // Reset during count with a simultaneous write
    bus_wr(32'h7f04, 32'd20);
    bus_wr(32'h7f00, 32'h9);
    run(5);
    reset = 1'b0; PrAddr = 32'h7f00; PrWD = 32'hF; PrWE = 1'b1;
    step();
    PrWE = 1'b0; reset = 1'b1;
    peek("t6_ctrl0", 32'h7f00, 32'd0);
    peek("t6_preset0", 32'h7f04, 32'd0);
    peek("t6_count0", 32'h7f08, 32'd0);
    peek("t6_ctrl1", 32'h7f10, 32'd0);
    peek("t6_preset1", 32'h7f14, 32'd0);
    peek("t6_count1", 32'h7f18, 32'd0);
    chk("t6_hwint_timers", {30'd0, HWInt[3:2]}, 32'd0);

    // Byte-lane write to PRESET
    PrBE = 4'b0001;
    bus_wr(32'h7f04, 32'hFFFF_FFFF);
    PrBE = 4'b0000;
`ifdef PR_BYTE_LANE_EN
    peek("t6_be_preset", 32'h7f04, 32'h0000_00FF);
`else
    peek("t6_be_preset", 32'h7f04, 32'hFFFF_FFFF);
`endif
    bus_wr(32'h7f04, 32'h1234_5678);
    peek("t6_full_word", 32'h7f04, 32'h1234_5678);
    run(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
